// File: rtl/conn_admit_fsm.sv
// conn_admit_fsm: connection-admission controller. Tracks active sessions
// against a ceiling with hysteresis re-opening, swap handling, an admin lock,
// error flagging and a saturating refusal counter. All outputs are registered.
module conn_admit_fsm #(
    parameter int MAX_CONN   = 3,
    parameter int RESUME_LVL = MAX_CONN - 1,
    parameter int CNT_W      = $clog2(MAX_CONN + 1),
    parameter int DROP_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        in,
    input  logic              lock,
    output logic              grant,
    output logic              deny,
    output logic              err,
    output logic              out,
    output logic [CNT_W-1:0]  count,
    output logic [DROP_W-1:0] drop_cnt
);

    typedef enum logic [1:0] {IDLE, OPEN, FULL, HOLD} state_t;

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_CONN);
    localparam logic [CNT_W-1:0] RES_C = CNT_W'(RESUME_LVL);

    state_t            state;
    state_t            n_state;
    logic [CNT_W-1:0]  n_cnt;
    logic              n_grant, n_deny, n_err, refuse, admit;

    // Decode the request against the current count/state/lock into the post-update count and pulses.
    always_comb begin
        n_cnt   = count;
        n_grant = 1'b0;
        n_deny  = 1'b0;
        n_err   = 1'b0;
        refuse  = 1'b0;
        // Only IDLE/OPEN admit new sessions; HOLD keeps refusing until drained to RESUME_LVL.
        admit   = ((state == IDLE) || (state == OPEN)) && !lock;
        case (in)
            2'b01: begin
                if (admit) begin
                    n_cnt   = count + CNT_W'(1);
                    n_grant = 1'b1;
                end else begin
                    n_deny = 1'b1;
                    refuse = 1'b1;
                end
            end
            2'b10: begin
                if (count != '0) n_cnt = count - CNT_W'(1);
                else             n_err = 1'b1;
            end
            2'b11: begin
                if (count == '0) begin
                    // Nobody to leave: flag it, then judge the join half as a plain connect.
                    n_err = 1'b1;
                    if (admit) begin
                        n_cnt   = count + CNT_W'(1);
                        n_grant = 1'b1;
                    end else begin
                        n_deny = 1'b1;
                        refuse = 1'b1;
                    end
                end else if (!lock) begin
                    // One out, one in: count unchanged, so even FULL/HOLD can grant.
                    n_grant = 1'b1;
                end else begin
                    n_cnt  = count - CNT_W'(1);
                    n_deny = 1'b1;
                    refuse = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Next-state selection from the post-update count, with hysteresis out of FULL/HOLD.
    always_comb begin
        if (n_cnt == '0)
            n_state = IDLE;
        else if (n_cnt == MAX_C)
            n_state = FULL;
        else if ((state == FULL) || (state == HOLD))
            n_state = (n_cnt <= RES_C) ? OPEN : HOLD;
        else
            n_state = OPEN;
    end

    // Register state, count, pulses, blocked flag and saturating refusal counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            count    <= '0;
            drop_cnt <= '0;
            grant    <= 1'b0;
            deny     <= 1'b0;
            err      <= 1'b0;
            out      <= 1'b0;
        end else begin
            state <= n_state;
            count <= n_cnt;
            grant <= n_grant;
            deny  <= n_deny;
            err   <= n_err;
            out   <= (n_state == FULL) || (n_state == HOLD) || lock;
            if (refuse && (drop_cnt != '1))
                drop_cnt <= drop_cnt + DROP_W'(1);
        end
    end

endmodule

// File: tb/tb_conn_admit_fsm.sv
// Directed bench: u0 is the reference configuration (3/1, 8-bit drops),
// u1 shares its stimulus with a 2-bit drop counter, u2 is MAX_CONN=1/RESUME_LVL=0.
module tb_conn_admit_fsm;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] in  = 2'b00;
    logic       lock = 1'b0;

    logic       g0, d0, e0, o0;
    logic [1:0] c0;
    logic [7:0] dr0;
    logic       g1, d1, e1, o1;
    logic [1:0] c1;
    logic [1:0] dr1;
    logic       g2, d2, e2, o2;
    logic [0:0] c2;
    logic [7:0] dr2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    conn_admit_fsm #(.MAX_CONN(3), .RESUME_LVL(1), .CNT_W(2), .DROP_W(8)) u0 (
        .clk(clk), .rst(rst), .in(in), .lock(lock),
        .grant(g0), .deny(d0), .err(e0), .out(o0), .count(c0), .drop_cnt(dr0));

    conn_admit_fsm #(.MAX_CONN(3), .RESUME_LVL(1), .CNT_W(2), .DROP_W(2)) u1 (
        .clk(clk), .rst(rst), .in(in), .lock(lock),
        .grant(g1), .deny(d1), .err(e1), .out(o1), .count(c1), .drop_cnt(dr1));

    conn_admit_fsm #(.MAX_CONN(1), .RESUME_LVL(0), .CNT_W(1), .DROP_W(8)) u2 (
        .clk(clk), .rst(rst), .in(in), .lock(lock),
        .grant(g2), .deny(d2), .err(e2), .out(o2), .count(c2), .drop_cnt(dr2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full output check of u0: grant, deny, err, out, count, drop_cnt.
    task automatic exp0(input string tag, input logic g, input logic d, input logic e,
                        input logic o, input logic [1:0] c, input logic [7:0] dr);
        chk({tag, ".grant"}, 32'(g0), 32'(g));
        chk({tag, ".deny"},  32'(d0), 32'(d));
        chk({tag, ".err"},   32'(e0), 32'(e));
        chk({tag, ".out"},   32'(o0), 32'(o));
        chk({tag, ".count"}, 32'(c0), 32'(c));
        chk({tag, ".drop"},  32'(dr0), 32'(dr));
    endtask

    task automatic exp2(input string tag, input logic g, input logic d, input logic o,
                        input logic c);
        chk({tag, ".grant"}, 32'(g2), 32'(g));
        chk({tag, ".deny"},  32'(d2), 32'(d));
        chk({tag, ".out"},   32'(o2), 32'(o));
        chk({tag, ".count"}, 32'(c2), 32'(c));
    endtask

    // Apply one request for one edge, then sample 1 time unit after the edge.
    task automatic step(input logic [1:0] req, input logic lk);
        in   = req;
        lock = lk;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset
        rst = 1'b1;
        step(2'b01, 1'b1);
        rst = 1'b0;
        exp0("reset", 0, 0, 0, 0, 0, 0);
        chk("reset.u1drop", 32'(dr1), 0);
        step(2'b00, 1'b0);
        exp0("idle_none", 0, 0, 0, 0, 0, 0);

        // 1: fill to the ceiling, then refuse
        step(2'b01, 1'b0); exp0("t1.c1", 1, 0, 0, 0, 1, 0);
        step(2'b01, 1'b0); exp0("t1.c2", 1, 0, 0, 0, 2, 0);
        step(2'b01, 1'b0); exp0("t1.c3", 1, 0, 0, 1, 3, 0);
        step(2'b01, 1'b0); exp0("t1.c4", 0, 1, 0, 1, 3, 1);

        // 2: hysteresis through HOLD
        step(2'b10, 1'b0); exp0("t2.dis1", 0, 0, 0, 1, 2, 1);
        step(2'b01, 1'b0); exp0("t2.hold_deny", 0, 1, 0, 1, 2, 2);
        step(2'b10, 1'b0); exp0("t2.dis2", 0, 0, 0, 0, 1, 2);
        step(2'b01, 1'b0); exp0("t2.reopen", 1, 0, 0, 0, 2, 2);

        // 3: swaps at FULL, locked swap drops into HOLD
        step(2'b01, 1'b0); exp0("t3.full", 1, 0, 0, 1, 3, 2);
        step(2'b11, 1'b0); exp0("t3.swap", 1, 0, 0, 1, 3, 2);
        step(2'b11, 1'b1); exp0("t3.lswap", 0, 1, 0, 1, 2, 3);
        chk("t3.u1drop", 32'(dr1), 3);
        step(2'b01, 1'b0); exp0("t3.hold", 0, 1, 0, 1, 2, 4);
        chk("t3.u1sat", 32'(dr1), 3);
        step(2'b10, 1'b0); exp0("t3.drain1", 0, 0, 0, 0, 1, 4);
        step(2'b10, 1'b0); exp0("t3.drain0", 0, 0, 0, 0, 0, 4);

        // 4: disconnect and swap at zero
        step(2'b10, 1'b0); exp0("t4.err", 0, 0, 1, 0, 0, 4);
        step(2'b11, 1'b0); exp0("t4.swap0", 1, 0, 1, 0, 1, 4);

        // 5: admin lock
        step(2'b01, 1'b1); exp0("t5.ldeny", 0, 1, 0, 1, 1, 5);
        chk("t5.u1sat", 32'(dr1), 3);
        step(2'b10, 1'b1); exp0("t5.ldis", 0, 0, 0, 1, 0, 5);
        step(2'b00, 1'b0); exp0("t5.unlock", 0, 0, 0, 0, 0, 5);
        step(2'b11, 1'b1); exp0("t5.lswap0", 0, 1, 1, 1, 0, 6);
        step(2'b00, 1'b0); exp0("t5.clr", 0, 0, 0, 0, 0, 6);

        // 6: reset mid-operation overrides in/lock
        step(2'b01, 1'b0);
        step(2'b01, 1'b0); exp0("t6.pre", 1, 0, 0, 0, 2, 6);
        rst = 1'b1;
        step(2'b01, 1'b1); exp0("t6.rst", 0, 0, 0, 0, 0, 0);
        chk("t6.u1drop", 32'(dr1), 0);
        chk("t6.u1cnt", 32'(c1), 0);
        rst = 1'b0;

        // MAX_CONN=1, RESUME_LVL=0: FULL drops straight to IDLE
        step(2'b01, 1'b0); exp2("m1.fill", 1, 0, 1, 1);
        step(2'b01, 1'b0); exp2("m1.deny", 0, 1, 1, 1);
        chk("m1.drop", 32'(dr2), 1);
        step(2'b10, 1'b0); exp2("m1.empty", 0, 0, 0, 0);
        step(2'b01, 1'b0); exp2("m1.again", 1, 0, 1, 1);
        step(2'b11, 1'b0); exp2("m1.swap", 1, 0, 1, 1);
        chk("m1.err", 32'(e2), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
